// File: rtl/tproc_in_pkg.sv
// Shared types and helpers for the tProc input-port capture stage.
// Port-index width, default entry layout and packed-vector slicing.
package tproc_in_pkg;

    localparam int MAX_IN_PORT = 16;
    localparam int PSEL_W      = 4;
    localparam int IN_DW       = 64;
    localparam int IN_TW       = 32;

    typedef struct packed {
        logic [IN_TW-1:0] tstamp;
        logic [IN_DW-1:0] data;
    } in_entry_t;

    // Base bit offset of lane `port` in a packed vector of `width`-bit lanes.
    function automatic int port_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/tproc_in_port_buffer_if.sv
// Bundle of sample inputs, pop request/response and per-port status for the input buffer.
// The slave side is the buffer itself; the master side is the surrounding core/fabric.
interface tproc_in_port_buffer_if
    import tproc_in_pkg::*;
#(
    parameter int IN_PORT_QTY = 8,
    parameter int DW          = 64,
    parameter int TW          = 32,
    parameter int FIFO_AW     = 3
);

    logic [IN_PORT_QTY*DW-1:0]          s_axis_tdata_i;
    logic [IN_PORT_QTY-1:0]             s_axis_tvalid_i;
    logic [TW-1:0]                      time_i;
    logic                               pop_i;
    logic [PSEL_W-1:0]                  pop_sel_i;
    logic                               flush_i;
    logic                               ovf_clr_i;

    logic [DW-1:0]                      rd_dt_o;
    logic [TW-1:0]                      rd_time_o;
    logic                               rd_valid_o;
    logic                               rd_udf_o;
    logic [IN_PORT_QTY*DW-1:0]          last_dt_o;
    logic [IN_PORT_QTY-1:0]             new_o;
    logic                               port_dt_new_o;
    logic [IN_PORT_QTY-1:0]             ovf_o;
    logic [IN_PORT_QTY*(FIFO_AW+1)-1:0] cnt_o;

    modport slave (
        input  s_axis_tdata_i, s_axis_tvalid_i, time_i, pop_i, pop_sel_i, flush_i, ovf_clr_i,
        output rd_dt_o, rd_time_o, rd_valid_o, rd_udf_o, last_dt_o, new_o, port_dt_new_o,
               ovf_o, cnt_o
    );

    modport master (
        output s_axis_tdata_i, s_axis_tvalid_i, time_i, pop_i, pop_sel_i, flush_i, ovf_clr_i,
        input  rd_dt_o, rd_time_o, rd_valid_o, rd_udf_o, last_dt_o, new_o, port_dt_new_o,
               ovf_o, cnt_o
    );

endinterface

// File: rtl/tproc_in_fifo.sv
// Per-port timestamped sample FIFO: push accepted same edge, head readable combinationally.
// No backpressure: a push into a full FIFO is dropped and sets a sticky overflow flag.
module tproc_in_fifo #(
    parameter int DW = 64,
    parameter int TW = 32,
    parameter int AW = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             ovf_clr_i,
    input  logic             push_i,
    input  logic [TW+DW-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             pop_ok_o,
    output logic [TW+DW-1:0] head_o,
    output logic [AW:0]      cnt_o,
    output logic             nonempty_o,
    output logic             ovf_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam int          EW       = TW + DW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          nonempty_q;
    logic          ovf_q, ovf_d;
    logic          full, empty, pop_ok, push_ok, ovf_set;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop_i && !empty && !flush_i;
    // A full FIFO still accepts a push when the same edge frees the head slot.
    assign push_ok = push_i && !flush_i && (!full || pop_ok);
    assign ovf_set = push_i && !flush_i && full && !pop_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
            else if (pop_ok && !push_ok) cnt_d = cnt_q - (AW+1)'(1);
            if (ovf_set)        ovf_d = 1'b1;
            else if (ovf_clr_i) ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            nonempty_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            nonempty_q <= (cnt_d != '0);
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_ok_o   = pop_ok;
    assign head_o     = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;
    assign nonempty_o = nonempty_q;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/tproc_in_port_buffer.sv
// tProc input capture: per-port timestamped FIFOs, last-value view, 1-cycle registered pop.
// No backpressure on s_axis; full-FIFO samples drop and flag overflow, empty pops flag underflow.
module tproc_in_port_buffer
    import tproc_in_pkg::*;
#(
    parameter int IN_PORT_QTY = 8,
    parameter int DW          = 64,
    parameter int TW          = 32,
    parameter int FIFO_AW     = 3
) (
    input  logic                   c_clk_i,
    input  logic                   c_rst_i,
    tproc_in_port_buffer_if.slave  bus
);

    localparam int EW = TW + DW;
    localparam int CW = FIFO_AW + 1;

    logic [EW-1:0]             head [IN_PORT_QTY];
    logic [DW-1:0]             last_q [IN_PORT_QTY];
    logic [IN_PORT_QTY-1:0]    pop_req, pop_ok, nonempty, ovf;
    logic [IN_PORT_QTY*CW-1:0] cnt_w;
    logic [IN_PORT_QTY*DW-1:0] last_w;

    logic [EW-1:0]             head_sel;
    logic [EW-1:0]             rd_ent_q, rd_ent_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      rd_udf_q, rd_udf_d;

    for (genvar p = 0; p < IN_PORT_QTY; p++) begin : g_port
        // Flush wins over a same-cycle pop, which then reports underflow.
        assign pop_req[p] = bus.pop_i && !bus.flush_i && (bus.pop_sel_i == PSEL_W'(p));

        tproc_in_fifo #(
            .DW (DW),
            .TW (TW),
            .AW (FIFO_AW)
        ) u_fifo (
            .clk_i      (c_clk_i),
            .rst_i      (c_rst_i),
            .flush_i    (bus.flush_i),
            .ovf_clr_i  (bus.ovf_clr_i),
            .push_i     (bus.s_axis_tvalid_i[p]),
            .push_dat_i ({bus.time_i, bus.s_axis_tdata_i[port_slice(p, DW) +: DW]}),
            .pop_i      (pop_req[p]),
            .pop_ok_o   (pop_ok[p]),
            .head_o     (head[p]),
            .cnt_o      (cnt_w[port_slice(p, CW) +: CW]),
            .nonempty_o (nonempty[p]),
            .ovf_o      (ovf[p])
        );

        always_ff @(posedge c_clk_i) begin
            if (c_rst_i)                       last_q[p] <= '0;
            else if (bus.s_axis_tvalid_i[p])   last_q[p] <= bus.s_axis_tdata_i[port_slice(p, DW) +: DW];
        end

        assign last_w[port_slice(p, DW) +: DW] = last_q[p];
    end

    always_comb begin
        head_sel = '0;
        for (int p = 0; p < IN_PORT_QTY; p++) begin
            if (pop_ok[p]) head_sel = head[p];
        end
        rd_valid_d = |pop_ok;
        rd_udf_d   = bus.pop_i && !(|pop_ok);
        rd_ent_d   = rd_valid_d ? head_sel : rd_ent_q;
    end

    always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
            rd_ent_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_udf_q   <= 1'b0;
        end else begin
            rd_ent_q   <= rd_ent_d;
            rd_valid_q <= rd_valid_d;
            rd_udf_q   <= rd_udf_d;
        end
    end

    assign bus.rd_dt_o       = rd_ent_q[DW-1:0];
    assign bus.rd_time_o     = rd_ent_q[EW-1:DW];
    assign bus.rd_valid_o    = rd_valid_q;
    assign bus.rd_udf_o      = rd_udf_q;
    assign bus.last_dt_o     = last_w;
    assign bus.new_o         = nonempty;
    assign bus.port_dt_new_o = |nonempty;
    assign bus.ovf_o         = ovf;
    assign bus.cnt_o         = cnt_w;

endmodule

// File: tb/tb_tproc_in_port_buffer.sv
// Randomized + directed bench for tproc_in_port_buffer with a queue-based reference model.
module tb_tproc_in_port_buffer;
    import tproc_in_pkg::*;

    localparam int NP = 8, DW = 64, TW = 32, AW = 3, DEPTH = 8, CW = AW + 1;

    typedef in_entry_t ent_t;
    typedef struct { bit v; bit u; logic [DW-1:0] d; logic [TW-1:0] t; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tproc_in_port_buffer_if #(.IN_PORT_QTY(NP), .DW(DW), .TW(TW), .FIFO_AW(AW)) bus ();

    tproc_in_port_buffer #(.IN_PORT_QTY(NP), .DW(DW), .TW(TW), .FIFO_AW(AW)) dut (
        .c_clk_i (clk),
        .c_rst_i (rst),
        .bus     (bus.slave)
    );

    ent_t          mq [NP][$];
    logic [NP-1:0] m_ovf = '0;
    logic [DW-1:0] m_last [NP];
    ent_t          hold = '0;
    exp_t          sb [$];
    logic [DW-1:0] dat [NP];
    int            n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic check_state();
        logic [NP-1:0] en;
        en = '0;
        for (int p = 0; p < NP; p++) begin
            en[p] = (mq[p].size() != 0);
            chk($sformatf("cnt%0d", p), 64'(bus.cnt_o[p*CW +: CW]), 64'(mq[p].size()));
            chk($sformatf("last_dt%0d", p), bus.last_dt_o[p*DW +: DW], m_last[p]);
        end
        chk("new_o", 64'(bus.new_o), 64'(en));
        chk("port_dt_new_o", 64'(bus.port_dt_new_o), 64'(|en));
        chk("ovf_o", 64'(bus.ovf_o), 64'(m_ovf));
    endtask

    // Apply one cycle of stimulus; the model predicts the edge, the pop result goes to the scoreboard.
    task automatic step(input logic [NP-1:0] vld, input logic pop, input logic [3:0] sel,
                        input logic flush, input logic clr, input logic [TW-1:0] tm, input logic rst_in);
        exp_t e;
        logic [NP-1:0] set;
        int s;
        rst = rst_in;
        bus.s_axis_tvalid_i = vld;
        for (int p = 0; p < NP; p++) bus.s_axis_tdata_i[p*DW +: DW] = dat[p];
        bus.time_i = tm;
        bus.pop_i = pop;
        bus.pop_sel_i = sel;
        bus.flush_i = flush;
        bus.ovf_clr_i = clr;
        set = '0;
        s = int'(sel);
        e.v = 1'b0;
        e.u = 1'b0;
        if (rst_in) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                m_last[p] = '0;
            end
            m_ovf = '0;
            hold = '0;
        end else begin
            if (pop) begin
                if (!flush && s < NP && mq[s].size() > 0) begin
                    hold = mq[s].pop_front();
                    e.v = 1'b1;
                end else begin
                    e.u = 1'b1;
                end
            end
            if (flush) for (int p = 0; p < NP; p++) mq[p].delete();
            for (int p = 0; p < NP; p++) begin
                if (vld[p]) begin
                    m_last[p] = dat[p];
                    if (!flush) begin
                        if (mq[p].size() < DEPTH) mq[p].push_back('{tstamp: tm, data: dat[p]});
                        else set[p] = 1'b1;
                    end
                end
            end
            m_ovf = flush ? '0 : ((clr ? '0 : m_ovf) | set);
        end
        e.d = hold.data;
        e.t = hold.tstamp;
        @(posedge clk);
        #1;
        sb.push_back(e);
        rst = 1'b0;
        bus.s_axis_tvalid_i = '0;
        bus.pop_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ovf_clr_i = 1'b0;
        check_state();
    endtask

    task automatic push1(input int p, input logic [DW-1:0] d, input logic [TW-1:0] tm);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        dat[p] = d;
        step(v, 1'b0, 4'd0, 1'b0, 1'b0, tm, 1'b0);
    endtask

    task automatic pop1(input int s);
        step('0, 1'b1, 4'(s), 1'b0, 1'b0, $urandom, 1'b0);
    endtask

    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("rd_valid_o", 64'(bus.rd_valid_o), 64'(me.v));
                chk("rd_udf_o", 64'(bus.rd_udf_o), 64'(me.u));
                chk("rd_dt_o", bus.rd_dt_o, me.d);
                chk("rd_time_o", 64'(bus.rd_time_o), 64'(me.t));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) begin
            dat[p] = '0;
            m_last[p] = '0;
        end
        bus.s_axis_tdata_i = '0;
        bus.s_axis_tvalid_i = '0;
        bus.time_i = '0;
        bus.pop_i = 1'b0;
        bus.pop_sel_i = '0;
        bus.flush_i = 1'b0;
        bus.ovf_clr_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset rd_valid_o", 64'(bus.rd_valid_o), 64'd0);
        chk("reset rd_udf_o", 64'(bus.rd_udf_o), 64'd0);
        chk("reset rd_dt_o", bus.rd_dt_o, 64'd0);
        chk("reset rd_time_o", 64'(bus.rd_time_o), 64'd0);
        check_state();

        // Single sample round trip on port 2.
        push1(2, 64'h1234, 32'd100);
        pop1(2);

        // Overflow on port 0, then drain in order and underflow.
        for (int i = 1; i <= 9; i++) push1(0, 64'(i), $urandom);
        for (int i = 0; i < 9; i++) pop1(0);

        // Full port 5: simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) push1(5, {$urandom, $urandom}, $urandom);
        dat[5] = 64'hAA;
        step(8'h20, 1'b1, 4'd5, 1'b0, 1'b0, $urandom, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop1(5);

        // Empty port 3: push and pop together, no bypass.
        dat[3] = 64'hC0FFEE;
        step(8'h08, 1'b1, 4'd3, 1'b0, 1'b0, 32'd77, 1'b0);
        pop1(3);

        // Flush beats a same-cycle push and pop.
        for (int i = 0; i < 9; i++) push1(1, {$urandom, $urandom}, $urandom);
        push1(6, 64'h600D, $urandom);
        dat[6] = 64'h6666;
        step(8'h40, 1'b1, 4'd1, 1'b1, 1'b0, $urandom, 1'b0);

        // Out-of-range pop index.
        push1(4, 64'h44, $urandom);
        pop1(12);
        pop1(4);

        // Overflow and clear in the same cycle: set wins; then a plain clear.
        for (int i = 0; i < DEPTH; i++) push1(4, {$urandom, $urandom}, $urandom);
        dat[4] = 64'hBAD;
        step(8'h10, 1'b0, 4'd0, 1'b0, 1'b1, $urandom, 1'b0);
        step('0, 1'b0, 4'd0, 1'b0, 1'b1, $urandom, 1'b0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NP; p++) begin
                dat[p] = {$urandom, $urandom};
                v[p] = ($urandom_range(0, 2) == 0);
            end
            step(v, 1'(($urandom_range(0, 1))), 4'($urandom_range(0, 9)),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom, 1'b0);
        end

        // Reset during a pop to a non-empty port suppresses the result.
        push1(7, 64'h7777, $urandom);
        step(8'h01, 1'b1, 4'd7, 1'b0, 1'b0, $urandom, 1'b1);
        step('0, 1'b0, 4'd0, 1'b0, 1'b0, $urandom, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
